// File: rtl/mem_bus_arb_pkg.sv
// Shared FSM state type, bus mux select encodings and small per-state decode
// helpers for the CPU memory bus arbiter.
package mem_bus_arb_pkg;

  typedef enum logic [2:0] {
    CPU_OWN     = 3'd0,
    HALT_WAIT   = 3'd1,
    DMA_OWN     = 3'd2,
    DBG_OWN     = 3'd3,
    RELEASE     = 3'd4,
    UNHALT_WAIT = 3'd5
  } arb_state_e;

  localparam logic [1:0] SEL_CPU  = 2'b00;
  localparam logic [1:0] SEL_DMA  = 2'b01;
  localparam logic [1:0] SEL_DBG  = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  // The CPU drives the bus while it runs or is waking up; gap states park the mux.
  function automatic logic [1:0] sel_for_state(input arb_state_e state);
    case (state)
      CPU_OWN, UNHALT_WAIT: sel_for_state = SEL_CPU;
      DMA_OWN:              sel_for_state = SEL_DMA;
      DBG_OWN:              sel_for_state = SEL_DBG;
      default:              sel_for_state = SEL_NONE;
    endcase
  endfunction

  function automatic logic halt_for_state(input arb_state_e state);
    halt_for_state = (state == HALT_WAIT) || (state == DMA_OWN) ||
                     (state == DBG_OWN)   || (state == RELEASE);
  endfunction

endpackage

// File: rtl/bus_arb_timer.sv
// Owned-cycle counter for the arbiter: load clears it, enable advances it, and
// expire flags the last cycle a grant is allowed to last.
module bus_arb_timer #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = enable && !load && (cnt_q == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// CPU memory bus arbiter: halts the CPU, hands the bus to debug or DMA by priority,
// then returns it. Define BUS_ARB_TIMEOUT_EN to bound each grant to TIMEOUT_CYCLES.
module mem_bus_arbiter
  import mem_bus_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dbg_req,
  output logic       dbg_gnt,
  input  logic       dma_req,
  output logic       dma_gnt,
  output logic       cpu_halt,
  input  logic       cpu_is_halted,
  output logic [1:0] bus_sel,
  output logic       busy,
  output logic       timeout
);

  arb_state_e state_q, state_d;
  logic       cpu_halt_q, cpu_halt_d;
  logic       dbg_gnt_q, dbg_gnt_d;
  logic       dma_gnt_q, dma_gnt_d;
  logic       busy_q, busy_d;
  logic [1:0] bus_sel_q, bus_sel_d;

  logic dbg_eff;
  logic dma_eff;
  logic any_eff;
  logic expire;

`ifdef BUS_ARB_TIMEOUT_EN
  logic owned;
  logic lock_dbg_q, lock_dbg_d;
  logic lock_dma_q, lock_dma_d;
  logic timeout_q, timeout_d;

  assign owned = (state_q == DMA_OWN) || (state_q == DBG_OWN);

  bus_arb_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (!owned),
    .enable (owned),
    .expire (expire)
  );

  // A requester cut off by the timer stays masked until it lets its req fall.
  always_comb begin
    timeout_d  = 1'b0;
    lock_dbg_d = lock_dbg_q & dbg_req;
    lock_dma_d = lock_dma_q & dma_req;
    if (expire && (state_q == DBG_OWN) && dbg_req) begin
      timeout_d  = 1'b1;
      lock_dbg_d = 1'b1;
    end
    if (expire && (state_q == DMA_OWN) && dma_req) begin
      timeout_d  = 1'b1;
      lock_dma_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_dbg_q <= 1'b0;
      lock_dma_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      lock_dbg_q <= lock_dbg_d;
      lock_dma_q <= lock_dma_d;
      timeout_q  <= timeout_d;
    end
  end

  assign dbg_eff = dbg_req & ~lock_dbg_q;
  assign dma_eff = dma_req & ~lock_dma_q;
  assign timeout = timeout_q;
`else
  assign dbg_eff = dbg_req;
  assign dma_eff = dma_req;
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  assign any_eff = dbg_eff | dma_eff;

  // Next state; every registered output is decoded from the state being entered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CPU_OWN: begin
        if (any_eff) state_d = HALT_WAIT;
      end
      HALT_WAIT: begin
        if (!any_eff)          state_d = RELEASE;
        else if (cpu_is_halted) state_d = dbg_eff ? DBG_OWN : DMA_OWN;
      end
      DMA_OWN: begin
        if (!dma_req || expire) state_d = RELEASE;
      end
      DBG_OWN: begin
        if (!dbg_req || expire) state_d = RELEASE;
      end
      RELEASE: begin
        // A CPU that never reached its halt point must be waited on again.
        if (!any_eff)           state_d = UNHALT_WAIT;
        else if (!cpu_is_halted) state_d = HALT_WAIT;
        else                    state_d = dbg_eff ? DBG_OWN : DMA_OWN;
      end
      UNHALT_WAIT: begin
        if (!cpu_is_halted) state_d = CPU_OWN;
      end
      default: state_d = CPU_OWN;
    endcase

    cpu_halt_d = halt_for_state(state_d);
    bus_sel_d  = sel_for_state(state_d);
    dbg_gnt_d  = (state_d == DBG_OWN);
    dma_gnt_d  = (state_d == DMA_OWN);
    busy_d     = (state_d != CPU_OWN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= CPU_OWN;
      cpu_halt_q <= 1'b0;
      dbg_gnt_q  <= 1'b0;
      dma_gnt_q  <= 1'b0;
      bus_sel_q  <= SEL_CPU;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cpu_halt_q <= cpu_halt_d;
      dbg_gnt_q  <= dbg_gnt_d;
      dma_gnt_q  <= dma_gnt_d;
      bus_sel_q  <= bus_sel_d;
      busy_q     <= busy_d;
    end
  end

  assign cpu_halt = cpu_halt_q;
  assign dbg_gnt  = dbg_gnt_q;
  assign dma_gnt  = dma_gnt_q;
  assign bus_sel  = bus_sel_q;
  assign busy     = busy_q;

  // Grants are exclusive and always agree with the mux select.
  assert property (@(posedge clk) disable iff (!rst) !(dbg_gnt_q && dma_gnt_q));
  assert property (@(posedge clk) disable iff (!rst) dma_gnt_q |-> (bus_sel_q == SEL_DMA));
  assert property (@(posedge clk) disable iff (!rst) dbg_gnt_q |-> (bus_sel_q == SEL_DBG));

endmodule
